// File: rtl/rv_ex_mem_pipe.sv
// EX->MEM pipeline stage: captures ALU outputs and control, resolves BEQ/BNE,
// and presents one registered entry behind a 2-entry skid buffer.
module rv_ex_mem_pipe #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic              alu_zero_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              reg_wr_i,
  input  logic              mem_rd_i,
  input  logic              mem_wr_i,
  input  logic              branch_i,
  input  logic              bne_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_wr_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic              branch_taken_o,
  output logic [XLEN-1:0]   branch_target_o,
  output logic [1:0]        occupancy_o
);

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   store;
    logic [XLEN-1:0]   target;
    logic [REG_AW-1:0] rd;
    logic              reg_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic              taken;
  } entry_t;

  entry_t in_e;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_v_q, main_v_d;
  logic   skid_v_q, skid_v_d;
  logic   accept;
  logic   emit;

  assign in_ready_o = ~skid_v_q;
  assign accept     = in_valid_i & in_ready_o;
  assign emit       = main_v_q & out_ready_i;

  always_comb begin
    in_e        = '0;
    in_e.result = alu_result_i;
    in_e.store  = rs2_data_i;
    in_e.target = pc_i + imm_i;
    in_e.rd     = rd_addr_i;
    in_e.reg_wr = reg_wr_i;
    in_e.mem_rd = mem_rd_i;
    in_e.mem_wr = mem_wr_i;
    in_e.taken  = branch_i & (alu_zero_i ^ bne_i);
  end

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || emit) begin
      // Skid always holds the older entry, so it refills main before any new input.
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_d   = '0;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d   = in_e;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = in_e;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign out_valid_o     = main_v_q;
  assign result_o        = main_q.result;
  assign store_data_o    = main_q.store;
  assign rd_addr_o       = main_q.rd;
  assign branch_target_o = main_q.target;
  assign reg_wr_o        = main_q.reg_wr & main_v_q;
  assign mem_rd_o        = main_q.mem_rd & main_v_q;
  assign mem_wr_o        = main_q.mem_wr & main_v_q;
  assign branch_taken_o  = main_q.taken & main_v_q;
  assign occupancy_o     = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule

// File: tb/tb_rv_ex_mem_pipe.sv
// Self-checking bench for rv_ex_mem_pipe: vector table plus hand-written
// back-pressure, flush and reset sequences, checked through a FIFO scoreboard.
module tb_rv_ex_mem_pipe;

  logic        clk_i = 1'b0;
  logic        rst_n_i, flush_i, in_valid_i, in_ready_o;
  logic [63:0] alu_result_i, rs2_data_i, pc_i, imm_i;
  logic        alu_zero_i;
  logic [4:0]  rd_addr_i;
  logic        reg_wr_i, mem_rd_i, mem_wr_i, branch_i, bne_i;
  logic        out_valid_o, out_ready_i;
  logic [63:0] result_o, store_data_o, branch_target_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wr_o, mem_rd_o, mem_wr_o, branch_taken_o;
  logic [1:0]  occupancy_o;

  rv_ex_mem_pipe #(.XLEN(64), .REG_AW(5)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .rs2_data_i(rs2_data_i), .pc_i(pc_i), .imm_i(imm_i),
    .rd_addr_i(rd_addr_i), .reg_wr_i(reg_wr_i), .mem_rd_i(mem_rd_i),
    .mem_wr_i(mem_wr_i), .branch_i(branch_i), .bne_i(bne_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .store_data_o(store_data_o), .rd_addr_o(rd_addr_o),
    .reg_wr_o(reg_wr_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
    .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] res, rs2, pc, imm;
    logic [4:0]  rd;
    logic        zero, rw, mr, mw, br, bne;
    logic        taken;
    logic [63:0] tgt;
  } vec_t;

  typedef struct {
    logic [63:0] res, rs2, tgt;
    logic [4:0]  rd;
    logic        rw, mr, mw, taken;
  } ex_t;

  int   checks = 0;
  int   errors = 0;
  int   emits  = 0;
  bit   mon_en = 1'b0;
  ex_t  sb[$];
  vec_t cur;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic ex_t to_ex(input vec_t v);
    ex_t e;
    e.res = v.res; e.rs2 = v.rs2; e.tgt = v.tgt; e.rd = v.rd;
    e.rw = v.rw; e.mr = v.mr; e.mw = v.mw; e.taken = v.taken;
    return e;
  endfunction

  function automatic vec_t mk(input logic [63:0] res);
    vec_t v;
    v.res = res; v.rs2 = {$urandom, $urandom}; v.pc = {$urandom, $urandom};
    v.imm = {$urandom, $urandom}; v.rd = 5'($urandom);
    v.zero = 1'($urandom); v.rw = 1'($urandom); v.mr = 1'($urandom);
    v.mw = 1'b1; v.br = 1'($urandom); v.bne = 1'($urandom);
    v.taken = v.br & (v.zero ^ v.bne);
    v.tgt = v.pc + v.imm;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic valid);
    cur = v;
    in_valid_i = valid;
    alu_result_i = v.res; rs2_data_i = v.rs2; pc_i = v.pc; imm_i = v.imm;
    rd_addr_i = v.rd; alu_zero_i = v.zero; reg_wr_i = v.rw; mem_rd_i = v.mr;
    mem_wr_i = v.mw; branch_i = v.br; bne_i = v.bne;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard monitor: check outputs mid-cycle, then advance the model for the next edge.
  always @(negedge clk_i) begin
    if (mon_en) begin
      chk("in_ready", 64'(in_ready_o), 64'(sb.size() < 2));
      chk("occupancy", 64'(occupancy_o), 64'(sb.size()));
      chk("out_valid", 64'(out_valid_o), 64'(sb.size() > 0));
      if (sb.size() > 0) begin
        chk("result", result_o, sb[0].res);
        chk("store_data", store_data_o, sb[0].rs2);
        chk("rd_addr", 64'(rd_addr_o), 64'(sb[0].rd));
        chk("reg_wr", 64'(reg_wr_o), 64'(sb[0].rw));
        chk("mem_rd", 64'(mem_rd_o), 64'(sb[0].mr));
        chk("mem_wr", 64'(mem_wr_o), 64'(sb[0].mw));
        chk("taken", 64'(branch_taken_o), 64'(sb[0].taken));
        chk("target", branch_target_o, sb[0].tgt);
      end else begin
        chk("idle_ctrl", 64'({reg_wr_o, mem_rd_o, mem_wr_o, branch_taken_o}), 64'd0);
      end
      if (!rst_n_i || flush_i) begin
        sb.delete();
      end else begin
        automatic bit acc = in_valid_i && (sb.size() < 2);
        if (sb.size() > 0 && out_ready_i) begin
          void'(sb.pop_front());
          emits++;
        end
        if (acc) sb.push_back(to_ex(cur));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    vec_t z, a, b, c;
    int   e0;
    z = '{default: '0};
    tbl[0] = '{res:64'h10, rs2:64'h0, pc:64'h0, imm:64'h0, rd:5'd5, zero:1'b0, rw:1'b1,
               mr:1'b0, mw:1'b0, br:1'b0, bne:1'b0, taken:1'b0, tgt:64'h0};
    tbl[1] = '{res:64'h0, rs2:64'h0, pc:64'h1000, imm:64'hFFFF_FFFF_FFFF_FFF0, rd:5'd0,
               zero:1'b1, rw:1'b0, mr:1'b0, mw:1'b0, br:1'b1, bne:1'b0, taken:1'b1, tgt:64'h0FF0};
    tbl[2] = '{res:64'h0, rs2:64'h0, pc:64'h1000, imm:64'hFFFF_FFFF_FFFF_FFF0, rd:5'd0,
               zero:1'b1, rw:1'b0, mr:1'b0, mw:1'b0, br:1'b1, bne:1'b1, taken:1'b0, tgt:64'h0FF0};
    tbl[3] = '{res:64'h7, rs2:64'h0, pc:64'hFFFF_FFFF_FFFF_FFF8, imm:64'd16, rd:5'd0,
               zero:1'b0, rw:1'b0, mr:1'b0, mw:1'b0, br:1'b1, bne:1'b1, taken:1'b1, tgt:64'h8};
    tbl[4] = '{res:64'h2000, rs2:64'hDEAD_BEEF, pc:64'h20, imm:64'h4, rd:5'd0,
               zero:1'b1, rw:1'b0, mr:1'b0, mw:1'b1, br:1'b0, bne:1'b0, taken:1'b0, tgt:64'h24};
    tbl[5] = '{res:64'h1, rs2:64'h0, pc:64'h100, imm:64'h40, rd:5'd3,
               zero:1'b0, rw:1'b0, mr:1'b0, mw:1'b0, br:1'b1, bne:1'b0, taken:1'b0, tgt:64'h140};
    tbl[6] = '{res:64'hFFFF_FFFF_FFFF_FFFF, rs2:64'h0, pc:64'h0, imm:64'h0, rd:5'd31,
               zero:1'b0, rw:1'b1, mr:1'b1, mw:1'b0, br:1'b0, bne:1'b0, taken:1'b0, tgt:64'h0};
    tbl[7] = '{res:64'h0, rs2:64'h55, pc:64'h8, imm:64'hFFFF_FFFF_FFFF_FFF8, rd:5'd9,
               zero:1'b1, rw:1'b0, mr:1'b0, mw:1'b0, br:1'b1, bne:1'b1, taken:1'b0, tgt:64'h0};

    rst_n_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    drive(z, 1'b0);
    step();
    mon_en = 1'b1;
    step();
    rst_n_i = 1'b1;
    chk("rst_result", result_o, 64'd0);
    chk("rst_store", store_data_o, 64'd0);
    chk("rst_target", branch_target_o, 64'd0);
    chk("rst_rd", 64'(rd_addr_o), 64'd0);

    // Single entry: visible one cycle after accept, gone the cycle after.
    drive(tbl[0], 1'b1);
    step();
    drive(z, 1'b0);
    chk("single_valid", 64'(out_valid_o), 64'd1);
    chk("single_result", result_o, 64'h10);
    step();
    chk("single_occ", 64'(occupancy_o), 64'd0);

    // Table vectors back-to-back at full throughput.
    e0 = emits;
    foreach (tbl[i]) begin
      drive(tbl[i], 1'b1);
      step();
      chk("stream_occ", 64'(occupancy_o), 64'd1);
    end
    drive(z, 1'b0);
    drain();
    chk("stream_emits", 64'(emits - e0), 64'd8);

    // Back-pressure: A held, B in skid, C refused until room.
    a = mk(64'hA); b = mk(64'hB); c = mk(64'hC);
    out_ready_i = 1'b0;
    drive(a, 1'b1); step();
    drive(b, 1'b1); step();
    drive(c, 1'b1); step(); step();
    chk("bp_occ", 64'(occupancy_o), 64'd2);
    chk("bp_ready", 64'(in_ready_o), 64'd0);
    chk("bp_head", result_o, 64'hA);
    out_ready_i = 1'b1;
    step();
    chk("bp_second", result_o, 64'hB);
    step();
    drive(z, 1'b0);
    chk("bp_third", result_o, 64'hC);
    drain();

    // Flush at occupancy 2 with a simultaneous input.
    out_ready_i = 1'b0;
    drive(mk(64'h11), 1'b1); step();
    drive(mk(64'h12), 1'b1); step();
    flush_i = 1'b1;
    drive(mk(64'h13), 1'b1); step();
    flush_i = 1'b0;
    drive(z, 1'b0);
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    chk("flush_occ", 64'(occupancy_o), 64'd0);
    chk("flush_memwr", 64'(mem_wr_o), 64'd0);
    chk("flush_ready", 64'(in_ready_o), 64'd1);
    out_ready_i = 1'b1;
    step(); step();
    chk("flush_stays_empty", 64'(out_valid_o), 64'd0);

    // Reset mid-stream at occupancy 2, then a fresh entry.
    out_ready_i = 1'b0;
    drive(mk(64'h21), 1'b1); step();
    drive(mk(64'h22), 1'b1); step();
    chk("prerst_occ", 64'(occupancy_o), 64'd2);
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    drive(z, 1'b0);
    chk("mrst_valid", 64'(out_valid_o), 64'd0);
    chk("mrst_result", result_o, 64'd0);
    chk("mrst_store", store_data_o, 64'd0);
    chk("mrst_target", branch_target_o, 64'd0);
    chk("mrst_rd", 64'(rd_addr_o), 64'd0);
    chk("mrst_ready", 64'(in_ready_o), 64'd1);
    out_ready_i = 1'b1;
    drive(tbl[1], 1'b1);
    step();
    drive(z, 1'b0);
    chk("postrst_valid", 64'(out_valid_o), 64'd1);
    chk("postrst_target", branch_target_o, 64'h0FF0);
    drain();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
